// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read controllers.
// Helpers work on a wide vector; callers zero-extend in and truncate out.
package fifo_ptr_pkg;

  localparam int PTR_WIDTH_DEF = 8;
  localparam int MAX_W         = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB; zero-extension leaves the low bits unaffected.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for a synchronized pointer.
module gray2bin_conv
  import fifo_ptr_pkg::*;
#(
  parameter int W = PTR_WIDTH_DEF + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  assign bin = W'(gray2bin(MAX_W'(gray)));

endmodule

// File: rtl/wptr_ctrl.sv
// Write-side pointer controller: pointers, full/almost-full, level/free and
// sticky overflow, all derived from the synchronized Gray read pointer.
module wptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AF_RESET  = 0
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  input  logic [PTR_WIDTH:0]   af_thresh,
  input  logic                 af_load,
  input  logic                 ovf_clr,
  output logic                 w_push,
  output logic [PTR_WIDTH-1:0] w_addr,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wr_level,
  output logic [PTR_WIDTH:0]   wr_free,
  output logic                 overflow
);

  localparam int             PW        = PTR_WIDTH + 1;
  localparam logic [PW-1:0]  DEPTH_V   = PW'(1) << PTR_WIDTH;
  localparam logic [PW-1:0]  AF_RST_V  = PW'(AF_RESET);
  // Full in Gray terms: top two bits inverted relative to the read pointer.
  localparam logic [PW-1:0]  FULL_MASK = PW'(3) << (PTR_WIDTH - 1);

  logic [PW-1:0] rptr_bin;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] level_next;
  logic [PW-1:0] thr;
  logic [PW-1:0] thr_in;
  logic          full_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (g_rptr_sync),
    .bin  (rptr_bin)
  );

  assign w_push     = w_en & ~full;
  assign b_next     = b_wptr + {{PTR_WIDTH{1'b0}}, w_push};
  assign g_next     = PW'(bin2gray(MAX_W'(b_next)));
  assign level_next = b_next - rptr_bin;
  assign full_next  = (level_next == DEPTH_V);
  assign thr_in     = (af_thresh > DEPTH_V) ? DEPTH_V : af_thresh;
  assign w_addr     = b_wptr[PTR_WIDTH-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      wr_free     <= DEPTH_V;
      overflow    <= 1'b0;
      thr         <= AF_RST_V;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      full        <= full_next;
      wr_level    <= level_next;
      wr_free     <= DEPTH_V - level_next;
      // The comparison uses the old threshold; a load takes effect next cycle.
      almost_full <= (thr != '0) && (level_next >= thr);
      if (af_load) thr <= thr_in;
      if (w_en & full)  overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  a_full_gray_equiv: assert property (@(posedge wclk) disable iff (!wrst_n)
    full_next == (g_next == (g_rptr_sync ^ FULL_MASK)));

endmodule

// File: tb/tb_wptr_ctrl.sv
// Randomized + directed bench for wptr_ctrl against a count-based FIFO model.
module tb_wptr_ctrl;

  localparam int PW_T  = 3;
  localparam int DEPTH = 8;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       w_en;
  logic [3:0] g_rptr_sync;
  logic [3:0] af_thresh;
  logic       af_load;
  logic       ovf_clr;
  logic       w_push;
  logic [2:0] w_addr;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_level;
  logic [3:0] wr_free;
  logic       overflow;

  wptr_ctrl #(.PTR_WIDTH(PW_T), .AF_RESET(0)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .af_thresh   (af_thresh),
    .af_load     (af_load),
    .ovf_clr     (ovf_clr),
    .w_push      (w_push),
    .w_addr      (w_addr),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .wr_free     (wr_free),
    .overflow    (overflow)
  );

  always #5 wclk = ~wclk;

  // Model: total items written/read since reset; everything else follows.
  int n_cmp = 0;
  int n_bad = 0;
  int wcnt, rcnt, thr;
  bit m_full, m_af, m_ovf;
  logic [3:0] prev_g;
  int  push_cnt;
  bit  seen_top, seen_wrap;

  function automatic int gray_of(int v);
    return (v ^ (v >> 1)) & 15;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; thr = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
    prev_g = 4'd0;
  endtask

  task automatic check_outs();
    int lvl;
    lvl = wcnt - rcnt;
    chk("b_wptr", b_wptr, wcnt % 16);
    chk("g_wptr", g_wptr, gray_of(wcnt % 16));
    chk("w_addr", w_addr, wcnt % 8);
    chk("full", full, m_full);
    chk("almost_full", almost_full, m_af);
    chk("wr_level", wr_level, lvl);
    chk("wr_free", wr_free, DEPTH - lvl);
    chk("overflow", overflow, m_ovf);
    chk("g_step", ($countones(g_wptr ^ prev_g) <= 1), 1);
    prev_g = g_wptr;
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic cycle(input bit we, input int rnew, input bit ld, input int th, input bit clr);
    int  lvl;
    bit  push;
    rcnt        = rnew;
    w_en        = we;
    g_rptr_sync = 4'(gray_of(rcnt % 16));
    af_load     = ld;
    af_thresh   = 4'(th);
    ovf_clr     = clr;
    #1;
    chk("w_push", w_push, we && !m_full);
    if (w_push) push_cnt++;
    @(posedge wclk);
    push = we && !m_full;
    if (we && m_full) m_ovf = 1;
    else if (clr)     m_ovf = 0;
    wcnt += int'(push);
    lvl    = wcnt - rcnt;
    m_full = (lvl == DEPTH);
    m_af   = (thr != 0) && (lvl >= thr);
    if (ld) thr = (th > DEPTH) ? DEPTH : th;
    @(negedge wclk);
    check_outs();
  endtask

  initial begin
    wrst_n = 1'b1; w_en = 0; g_rptr_sync = 0; af_thresh = 0; af_load = 0; ovf_clr = 0;
    model_reset();
    #2 wrst_n = 1'b0;
    #1 check_outs();
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;

    // Fill from empty with the reader parked; two writes hit a full FIFO.
    push_cnt = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
    chk("t1_push_count", push_cnt, 8);
    chk("t1_gray_full", g_wptr, 12);

    // Reader advances by one, then by another.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 2, 0, 0, 0);

    // Drain, load threshold 5, write 5, read one.
    cycle(0, wcnt, 1, 5, 0);
    for (int i = 0; i < 5; i++) cycle(1, rcnt, 0, 0, 0);
    cycle(0, rcnt + 1, 0, 0, 0);
    cycle(0, rcnt, 0, 0, 0);

    // Long stream with the reader two behind; crosses the pointer wrap.
    seen_top = 0; seen_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, wcnt - 1, 0, 0, 0);
      if (b_wptr == 4'd15) seen_top = 1;
      else if (seen_top && b_wptr == 4'd0) seen_wrap = 1;
    end
    chk("t4_wrap_seen", seen_wrap, 1);

    // Overflow: clear, refill, set+clear together, then plain clear.
    cycle(0, rcnt, 0, 0, 1);
    while (!m_full) cycle(1, rcnt, 0, 0, 0);
    cycle(1, rcnt, 0, 0, 1);
    cycle(0, rcnt, 0, 0, 1);

    // Drain to level 5, then async reset mid-stream.
    cycle(0, wcnt - 5, 1, 3, 0);
    cycle(1, rcnt, 0, 0, 0);
    #2;
    wrst_n = 1'b0;
    rcnt = 0; g_rptr_sync = 4'd0; w_en = 0;
    model_reset();
    #1 check_outs();
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);

    // Random traffic with legal reader advances and random threshold loads.
    for (int i = 0; i < 400; i++) begin
      int rn;
      rn = rcnt + int'($urandom_range(0, 1));
      if (rn > wcnt) rn = wcnt;
      cycle($urandom_range(0, 3) != 0, rn, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
